// File: rtl/enable_pulse_gen_if.sv
// Handshake bundle between the step/run controller and the enable pulse generator.
interface enable_pulse_gen_if;
    logic run_mode;
    logic btn_step;
    logic enable;
    logic running;
    logic btn_level;

    modport master (
        output run_mode,
        output btn_step,
        input  enable,
        input  running,
        input  btn_level
    );

    modport slave (
        input  run_mode,
        input  btn_step,
        output enable,
        output running,
        output btn_level
    );
endinterface

// File: rtl/enable_pulse_gen.sv
// Enable pulse source for the up counter: prescaled free-run pulses in RUN,
// one pulse per debounced button press in STOP.
module enable_pulse_gen #(
    parameter int unsigned PRESCALE        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    enable_pulse_gen_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        STOP = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2
    } state_t;

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] db_cnt;
    logic             btn_level;
    logic             btn_level_d;
    logic [PRE_W-1:0] pre_cnt;
    logic             enable;
    logic             running;
    state_t           state;
    logic             press_c;

    assign press_c = btn_level & ~btn_level_d;

    // Synchronizer and debouncer: a new level is accepted only after
    // DEBOUNCE_CYCLES consecutive disagreeing synchronized samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            db_cnt      <= '0;
            btn_level   <= 1'b0;
            btn_level_d <= 1'b0;
        end else begin
            s1          <= bus.btn_step;
            s2          <= s1;
            btn_level_d <= btn_level;
            if (s2 != btn_level) begin
                if (db_cnt == DB_LAST) begin
                    btn_level <= s2;
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Mode FSM with registered enable/running; run_mode beats a coincident press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= STOP;
            pre_cnt <= '0;
            enable  <= 1'b0;
            running <= 1'b0;
        end else begin
            enable <= 1'b0;
            case (state)
                STOP: begin
                    if (bus.run_mode) begin
                        state   <= RUN;
                        pre_cnt <= '0;
                        running <= 1'b1;
                    end else if (press_c) begin
                        state  <= STEP;
                        enable <= 1'b1;
                    end
                end
                STEP: begin
                    state <= STOP;
                end
                RUN: begin
                    if (!bus.run_mode) begin
                        state   <= STOP;
                        running <= 1'b0;
                    end else if (pre_cnt == PRE_LAST) begin
                        pre_cnt <= '0;
                        enable  <= 1'b1;
                    end else begin
                        pre_cnt <= pre_cnt + PRE_W'(1);
                    end
                end
                default: begin
                    state   <= STOP;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.enable    = enable;
    assign bus.running   = running;
    assign bus.btn_level = btn_level;

endmodule

// File: tb/tb_enable_pulse_gen.sv
// Directed bench for enable_pulse_gen: vector table for reset/step/debounce,
// hand sequences for run mode, priority, reset abort and PRESCALE=1.
module tb_enable_pulse_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    enable_pulse_gen_if bus();
    enable_pulse_gen_if bus1();

    enable_pulse_gen #(.PRESCALE(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    enable_pulse_gen #(.PRESCALE(1), .DEBOUNCE_CYCLES(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct packed {
        logic rst;
        logic run;
        logic btn;
        logic en;
        logic rn;
        logic lvl;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(logic r, logic run, logic b, logic en, logic rn, logic lv);
        vec_t v;
        v.rst = r; v.run = run; v.btn = b; v.en = en; v.rn = rn; v.lvl = lv;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int pat[10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

        rst = 1'b1;
        bus.run_mode  = 1'b0;
        bus.btn_step  = 1'b0;
        bus1.run_mode = 1'b0;
        bus1.btn_step = 1'b0;

        // reset held with toggling inputs
        add(1, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        // clean step: pulse after posedge 6, none on release
        for (int j = 1; j <= 12; j++) add(0, 0, 1, 1'(j == 6), 0, 1'(j >= 5));
        for (int k = 1; k <= 7; k++)  add(0, 0, 0, 0, 0, 1'(k < 5));
        // two-cycle glitch is rejected
        for (int g = 1; g <= 8; g++)  add(0, 0, 1'(g <= 2), 0, 0, 0);
        // bouncy press: level at posedge 10, single pulse at 11
        for (int i = 1; i <= 10; i++) add(0, 0, 1'(pat[i-1]), 0, 0, 1'(i >= 10));
        for (int i = 11; i <= 14; i++) add(0, 0, 1, 1'(i == 11), 0, 1);
        for (int k = 1; k <= 5; k++)  add(0, 0, 0, 0, 0, 1'(k < 5));

        foreach (vecs[n]) begin
            rst          = vecs[n].rst;
            bus.run_mode = vecs[n].run;
            bus.btn_step = vecs[n].btn;
            tick();
            chk($sformatf("vec%0d.enable", n),    bus.enable,    vecs[n].en);
            chk($sformatf("vec%0d.running", n),   bus.running,   vecs[n].rn);
            chk($sformatf("vec%0d.btn_level", n), bus.btn_level, vecs[n].lvl);
        end

        // run mode: pulses every 4th posedge, press inside RUN ignored
        bus.run_mode = 1'b1;
        tick();
        chk("run.entry.running", bus.running, 1'b1);
        chk("run.entry.enable",  bus.enable,  1'b0);
        bus.btn_step = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            tick();
            chk($sformatf("run.n%0d.enable", n),  bus.enable,  1'((n % 4) == 0));
            chk($sformatf("run.n%0d.running", n), bus.running, 1'b1);
        end
        bus.run_mode = 1'b0;
        tick();
        chk("run.drop_on_tick.enable",  bus.enable,  1'b0);
        chk("run.drop_on_tick.running", bus.running, 1'b0);
        for (int n = 1; n <= 5; n++) begin
            tick();
            chk($sformatf("run.after%0d.enable", n), bus.enable,  1'b0);
            chk($sformatf("run.after%0d.running", n), bus.running, 1'b0);
        end
        chk("run.held.btn_level", bus.btn_level, 1'b1);
        bus.btn_step = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            chk($sformatf("run.rel%0d.enable", n), bus.enable, 1'b0);
        end
        chk("run.rel.btn_level", bus.btn_level, 1'b0);

        // press and run_mode in the same STOP cycle: RUN wins, no STEP
        bus.btn_step = 1'b1;
        for (int j = 1; j <= 5; j++) tick();
        chk("prio.btn_level", bus.btn_level, 1'b1);
        bus.run_mode = 1'b1;
        tick();
        chk("prio.running", bus.running, 1'b1);
        chk("prio.enable",  bus.enable,  1'b0);
        bus.run_mode = 1'b0;
        tick();
        chk("prio.exit.running", bus.running, 1'b0);
        chk("prio.exit.enable",  bus.enable,  1'b0);
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk($sformatf("prio.idle%0d.enable", j), bus.enable, 1'b0);
        end
        bus.btn_step = 1'b0;
        for (int j = 1; j <= 6; j++) tick();
        chk("prio.rel.btn_level", bus.btn_level, 1'b0);

        // reset in the STEP cycle, then a button held across reset release
        bus.btn_step = 1'b1;
        for (int j = 1; j <= 5; j++) tick();
        tick();
        chk("rststep.step.enable", bus.enable, 1'b1);
        rst = 1'b1;
        tick();
        chk("rststep.enable",    bus.enable,    1'b0);
        chk("rststep.btn_level", bus.btn_level, 1'b0);
        chk("rststep.running",   bus.running,   1'b0);
        rst = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk($sformatf("held.j%0d.enable", j),    bus.enable,    1'(j == 6));
            chk($sformatf("held.j%0d.btn_level", j), bus.btn_level, 1'(j >= 5));
        end
        bus.btn_step = 1'b0;
        for (int j = 1; j <= 6; j++) tick();

        // PRESCALE=1: enable high every RUN cycle
        bus1.run_mode = 1'b1;
        tick();
        chk("p1.entry.running", bus1.running, 1'b1);
        chk("p1.entry.enable",  bus1.enable,  1'b0);
        for (int j = 1; j <= 5; j++) begin
            tick();
            chk($sformatf("p1.j%0d.enable", j),  bus1.enable,  1'b1);
            chk($sformatf("p1.j%0d.running", j), bus1.running, 1'b1);
        end
        bus1.run_mode = 1'b0;
        tick();
        chk("p1.exit.enable",  bus1.enable,  1'b0);
        chk("p1.exit.running", bus1.running, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
